// File: rtl/wb_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter_pkg
// Shared definitions for the two-requester Wishbone master arbiter:
//   - arbiter state encoding (IDLE / OWN0 / OWN1 / DRAIN)
//   - requester port index constants
//   - default bus widths
//   - the arbitration helper used from IDLE and on owner release
// -----------------------------------------------------------------------------
package wb_master_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // OWN0/OWN1 encodings equal the one-hot grant vector of their owner.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN0  = 2'b01,
        ST_OWN1  = 2'b10,
        ST_DRAIN = 2'b11
    } arb_state_e;

    // Pick the next owner from the raw cyc requests. On a tie the winner is
    // the fixed high-priority port, or the port that did not own the bus
    // last when round robin is enabled.
    function automatic arb_state_e arbitrate(
        input logic req0,
        input logic req1,
        input logic hi_prio,
        input logic round_robin,
        input logic last_owner
    );
        arb_state_e res;
        logic       tie_winner;
        tie_winner = round_robin ? ~last_owner : hi_prio;
        if (req0 && req1) begin
            res = (tie_winner == PORT1) ? ST_OWN1 : ST_OWN0;
        end else if (req0) begin
            res = ST_OWN0;
        end else if (req1) begin
            res = ST_OWN1;
        end else begin
            res = ST_IDLE;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// wb_watchdog
// Bus watchdog for the master arbiter. Counts owned cycles without ACK,
// saturates at TIMEOUT and flags expiry while the bus is owned. TIMEOUT = 0
// disables the watchdog entirely.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  asynchronous active-high reset
//   clear_i    in  clear the counter (idle, new grant, or slave ACK)
//   incr_i     in  owner is holding cyc this cycle
//   own_i      in  arbiter is in an OWN state
//   ack_i      in  slave ACK this cycle
//   expired_o  out counter at TIMEOUT with no ACK while owned
// -----------------------------------------------------------------------------
module wb_watchdog
    import wb_master_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic incr_i,
    input  logic own_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
    localparam logic          ENABLED = (TIMEOUT != 0) ? 1'b1 : 1'b0;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next counter value: clear has priority, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (ENABLED && incr_i && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is combinational so the abort lands in the cycle the count hits TIMEOUT.
    assign expired_o = ENABLED && own_i && !ack_i && (count_q == LIMIT);

endmodule

// File: rtl/wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter
// Shares the CPU's single Wishbone master port between the instruction fetch
// unit (port 0) and the load/store unit (port 1). The bus is granted for a
// whole CYC cycle; the owner's signals are muxed out and ACK/STALL/ERR go
// back to the owner only. A watchdog aborts a stuck cycle with ERR and the
// arbiter then waits in DRAIN until the former owner drops cyc.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   mN_cyc/stb/we/addr/data_w  requester N bus request (N = 0, 1)
//   mN_ack/stall/err/data_r    responses to requester N
//   o_wb_cyc/stb, o_we,
//   o_addr, o_data             muxed bus towards the interconnect
//   i_wb_ack/stall, i_data     slave responses
//   o_grant                    one-hot current owner, 0 when nobody owns
// -----------------------------------------------------------------------------
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int HI_PRIO_PORT = 1,
    parameter int ROUND_ROBIN  = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_data_w,
    output logic                  m0_ack,
    output logic                  m0_stall,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_data_r,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_data_w,
    output logic                  m1_ack,
    output logic                  m1_stall,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_data_r,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [1:0]            o_grant
);

    localparam logic HI_PRIO_BIT = (HI_PRIO_PORT != 0) ? 1'b1 : 1'b0;
    localparam logic RR_BIT      = (ROUND_ROBIN != 0) ? 1'b1 : 1'b0;
    localparam int   CW          = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic       grant_s;
    logic       own_s;
    logic       owner_cyc_s;
    logic       former_cyc_s;
    logic       wd_clear_s;
    logic       wd_expired_s;

    assign own_s        = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign owner_cyc_s  = (state_q == ST_OWN1) ? m1_cyc : m0_cyc;
    // In DRAIN the last granted port is the former owner.
    assign former_cyc_s = (last_q == PORT1) ? m1_cyc : m0_cyc;
    assign wd_clear_s   = (state_q == ST_IDLE) || grant_s || i_wb_ack;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear_s),
        .incr_i    (own_s && owner_cyc_s),
        .own_i     (own_s),
        .ack_i     (i_wb_ack),
        .expired_o (wd_expired_s)
    );

    // Next-state logic: arbitration from IDLE or on release, abort to DRAIN.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = arbitrate(m0_cyc, m1_cyc, HI_PRIO_BIT, RR_BIT, last_q);
            end
            ST_OWN0: begin
                if (wd_expired_s) begin
                    state_d = ST_DRAIN;
                end else if (!m0_cyc) begin
                    // Release: the other port may be granted at this same edge.
                    state_d = arbitrate(m0_cyc, m1_cyc, HI_PRIO_BIT, RR_BIT, last_q);
                end else begin
                    state_d = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (wd_expired_s) begin
                    state_d = ST_DRAIN;
                end else if (!m1_cyc) begin
                    state_d = arbitrate(m0_cyc, m1_cyc, HI_PRIO_BIT, RR_BIT, last_q);
                end else begin
                    state_d = ST_OWN1;
                end
            end
            ST_DRAIN: begin
                if (!former_cyc_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (((state_d == ST_OWN0) || (state_d == ST_OWN1)) && (state_d != state_q)) begin
            grant_s = 1'b1;
            last_d  = (state_d == ST_OWN1) ? PORT1 : PORT0;
        end else begin
            grant_s = 1'b0;
            last_d  = last_q;
        end
    end

    // State and last-owner registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= PORT0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Bus mux and response routing, combinational from the current owner.
    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        o_we     = 1'b0;
        o_addr   = {ADDR_WIDTH{1'b0}};
        o_data   = {DATA_WIDTH{1'b0}};
        o_grant  = 2'b00;
        m0_ack   = 1'b0;
        m0_stall = 1'b1;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_stall = 1'b1;
        m1_err   = 1'b0;
        case (state_q)
            ST_OWN0: begin
                // A watchdog abort forces cyc/stb low in the expiry cycle.
                o_wb_cyc = m0_cyc && !wd_expired_s;
                o_wb_stb = m0_cyc && m0_stb && !wd_expired_s;
                o_we     = m0_we;
                o_addr   = m0_addr;
                o_data   = m0_data_w;
                o_grant  = 2'b01;
                m0_ack   = i_wb_ack;
                m0_stall = i_wb_stall;
                m0_err   = wd_expired_s;
            end
            ST_OWN1: begin
                o_wb_cyc = m1_cyc && !wd_expired_s;
                o_wb_stb = m1_cyc && m1_stb && !wd_expired_s;
                o_we     = m1_we;
                o_addr   = m1_addr;
                o_data   = m1_data_w;
                o_grant  = 2'b10;
                m1_ack   = i_wb_ack;
                m1_stall = i_wb_stall;
                m1_err   = wd_expired_s;
            end
            default: begin
                // IDLE and DRAIN: bus quiet, stray ACKs dropped, both stalled.
                o_wb_cyc = 1'b0;
                o_grant  = 2'b00;
            end
        endcase
    end

    // Read data is broadcast; requesters qualify it with their ACK.
    assign m0_data_r = i_data;
    assign m1_data_r = i_data;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_master_arbiter
// Directed bench. Two arbiter instances share all stimulus:
//   dut_a: HI_PRIO_PORT=1, ROUND_ROBIN=0, TIMEOUT=4
//   dut_b: HI_PRIO_PORT=1, ROUND_ROBIN=1, TIMEOUT=0 (watchdog off)
// Each section resets both and checks only the instance it targets.
// -----------------------------------------------------------------------------
module tb_wb_master_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_addr, m0_data_w;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_addr, m1_data_w;
    logic        i_wb_ack, i_wb_stall;
    logic [31:0] i_data;

    logic        a_m0_ack, a_m0_stall, a_m0_err, a_m1_ack, a_m1_stall, a_m1_err;
    logic [31:0] a_m0_data_r, a_m1_data_r, a_addr, a_data;
    logic        a_cyc, a_stb, a_we;
    logic [1:0]  a_grant;

    logic        b_m0_ack, b_m0_stall, b_m0_err, b_m1_ack, b_m1_stall, b_m1_err;
    logic [31:0] b_m0_data_r, b_m1_data_r, b_addr, b_data;
    logic        b_cyc, b_stb, b_we;
    logic [1:0]  b_grant;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    wb_master_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .HI_PRIO_PORT(1), .ROUND_ROBIN(0), .TIMEOUT(4)
    ) dut_a (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data_w(m0_data_w),
        .m0_ack(a_m0_ack), .m0_stall(a_m0_stall), .m0_err(a_m0_err), .m0_data_r(a_m0_data_r),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data_w(m1_data_w),
        .m1_ack(a_m1_ack), .m1_stall(a_m1_stall), .m1_err(a_m1_err), .m1_data_r(a_m1_data_r),
        .o_wb_cyc(a_cyc), .o_wb_stb(a_stb), .o_we(a_we), .o_addr(a_addr), .o_data(a_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_data(i_data), .o_grant(a_grant)
    );

    wb_master_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .HI_PRIO_PORT(1), .ROUND_ROBIN(1), .TIMEOUT(0)
    ) dut_b (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data_w(m0_data_w),
        .m0_ack(b_m0_ack), .m0_stall(b_m0_stall), .m0_err(b_m0_err), .m0_data_r(b_m0_data_r),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data_w(m1_data_w),
        .m1_ack(b_m1_ack), .m1_stall(b_m1_stall), .m1_err(b_m1_err), .m1_data_r(b_m1_data_r),
        .o_wb_cyc(b_cyc), .o_wb_stb(b_stb), .o_we(b_we), .o_addr(b_addr), .o_data(b_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_data(i_data), .o_grant(b_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_data_w = 32'h0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_data_w = 32'h0;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_data = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        reset = 1'b1;
        clear_inputs();
        #3;
        chk("rst_grant", a_grant, 32'd0);
        chk("rst_cyc", a_cyc, 32'd0);
        chk("rst_stb", a_stb, 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_m0_stall", a_m0_stall, 32'd1);
        chk("rst_m1_stall", a_m1_stall, 32'd1);
        chk("rst_m0_ack", a_m0_ack, 32'd0);
        chk("rst_m0_err", a_m0_err, 32'd0);
        chk("rst_b_grant", b_grant, 32'd0);
        tick();
        reset = 1'b0;

        // ---------------- single request on port 0 ----------------
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'hb000_0000;
        settle();
        chk("single_latency_cyc", a_cyc, 32'd0);
        chk("single_latency_grant", a_grant, 32'd0);
        tick();
        settle();
        chk("single_cyc", a_cyc, 32'd1);
        chk("single_stb", a_stb, 32'd1);
        chk("single_addr", a_addr, 32'hb000_0000);
        chk("single_grant", a_grant, 32'd1);
        chk("single_m1_stall", a_m1_stall, 32'd1);
        tick();
        m0_stb = 1'b0;
        settle();
        chk("single_stb_drop", a_stb, 32'd0);
        chk("single_no_ack", a_m0_ack, 32'd0);
        tick();
        i_wb_ack = 1'b1; i_data = 32'h1234_5678;
        settle();
        chk("single_ack", a_m0_ack, 32'd1);
        chk("single_rdata", a_m0_data_r, 32'h1234_5678);
        chk("single_m1_ack", a_m1_ack, 32'd0);
        chk("single_m1_stall2", a_m1_stall, 32'd1);
        tick();
        i_wb_ack = 1'b0; m0_cyc = 1'b0;
        settle();
        chk("single_release_cyc", a_cyc, 32'd0);
        tick();
        settle();
        chk("single_idle_grant", a_grant, 32'd0);

        // ---------------- simultaneous request, port 1 high priority ----------------
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 32'h1000_0000; m0_data_w = 32'haaaa_5555;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 32'h2000_0004;
        tick();
        settle();
        chk("prio_grant", a_grant, 32'd2);
        chk("prio_addr", a_addr, 32'h2000_0004);
        chk("prio_we", a_we, 32'd0);
        chk("prio_m0_stall", a_m0_stall, 32'd1);
        i_wb_ack = 1'b1;
        settle();
        chk("prio_m1_ack", a_m1_ack, 32'd1);
        chk("prio_m0_ack", a_m0_ack, 32'd0);
        tick();
        i_wb_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        settle();
        chk("prio_hold_grant", a_grant, 32'd2);
        tick();
        settle();
        chk("prio_handover_grant", a_grant, 32'd1);
        chk("prio_handover_cyc", a_cyc, 32'd1);
        chk("prio_handover_addr", a_addr, 32'h1000_0000);
        chk("prio_handover_we", a_we, 32'd1);
        chk("prio_handover_data", a_data, 32'haaaa_5555);
        i_wb_ack = 1'b1;
        settle();
        chk("prio_m0_ack2", a_m0_ack, 32'd1);
        tick();
        i_wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        tick();
        settle();
        chk("prio_idle", a_grant, 32'd0);

        // ---------------- stray ACK in IDLE, stall mirroring, counting under stall ----------------
        i_wb_ack = 1'b1;
        settle();
        chk("stray_m0_ack", a_m0_ack, 32'd0);
        chk("stray_m1_ack", a_m1_ack, 32'd0);
        tick();
        i_wb_ack = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_0040; i_wb_stall = 1'b1;
        tick();
        settle();
        chk("stall_mirror1", a_m0_stall, 32'd1);
        chk("stall_cyc", a_cyc, 32'd1);
        tick();
        tick();
        settle();
        chk("stall_mirror3", a_m0_stall, 32'd1);
        tick();
        i_wb_stall = 1'b0;
        settle();
        chk("stall_mirror_low", a_m0_stall, 32'd0);
        chk("stall_no_err_yet", a_m0_err, 32'd0);
        tick();
        settle();
        // Four owned cycles have elapsed, three of them stalled.
        chk("stall_wd_err", a_m0_err, 32'd1);
        chk("stall_wd_cyc", a_cyc, 32'd0);
        chk("stall_wd_stb", a_stb, 32'd0);
        chk("stall_wd_m1_err", a_m1_err, 32'd0);
        tick();
        i_wb_ack = 1'b1;
        settle();
        chk("drain_err_pulse", a_m0_err, 32'd0);
        chk("drain_stray_ack", a_m0_ack, 32'd0);
        chk("drain_stall", a_m0_stall, 32'd1);
        tick();
        i_wb_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        settle();
        chk("drain_exit_idle", a_grant, 32'd0);

        // ---------------- watchdog on port 1, port 0 waiting ----------------
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h3000_0000;
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("wd_no_err", a_m1_err, 32'd0);
            chk("wd_cyc_high", a_cyc, 32'd1);
            tick();
        end
        settle();
        chk("wd_err", a_m1_err, 32'd1);
        chk("wd_cyc_low", a_cyc, 32'd0);
        chk("wd_m0_err", a_m0_err, 32'd0);
        tick();
        settle();
        chk("wd_err_once", a_m1_err, 32'd0);
        chk("wd_drain_cyc", a_cyc, 32'd0);
        chk("wd_drain_stall", a_m1_stall, 32'd1);
        tick();
        settle();
        chk("wd_drain_hold", a_grant, 32'd0);
        chk("wd_drain_hold_cyc", a_cyc, 32'd0);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        settle();
        chk("wd_no_grant_from_drain", a_grant, 32'd0);
        tick();
        settle();
        chk("wd_m0_served", a_grant, 32'd1);
        chk("wd_m0_addr", a_addr, 32'h0000_1000);

        // ---------------- round robin on dut_b ----------------
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        settle();
        chk("rr_pre_grant", b_grant, 32'd2);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        // Port 1 owned last, so the tie goes to port 0 despite HI_PRIO_PORT=1.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h4000_0000;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h5000_0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_grant", b_grant, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_addr", b_addr, (i % 2 == 0) ? 32'h4000_0000 : 32'h5000_0000);
            i_wb_ack = 1'b1;
            settle();
            chk("rr_ack", (i % 2 == 0) ? b_m0_ack : b_m1_ack, 32'd1);
            tick();
            i_wb_ack = 1'b0;
            if (i % 2 == 0) begin
                m0_cyc = 1'b0;
            end else begin
                m1_cyc = 1'b0;
            end
            tick();
            m0_cyc = 1'b1;
            m1_cyc = 1'b1;
        end
        // Watchdog disabled: port 0 may hold the bus without ACK indefinitely.
        m1_cyc = 1'b0; m1_stb = 1'b0;
        repeat (8) tick();
        settle();
        chk("rr_nowd_err", b_m0_err, 32'd0);
        chk("rr_nowd_cyc", b_cyc, 32'd1);
        chk("rr_nowd_grant", b_grant, 32'd1);

        // ---------------- asynchronous reset mid-cycle ----------------
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h6000_0000;
        tick();
        settle();
        chk("arst_pre_grant", a_grant, 32'd2);
        chk("arst_pre_stb", a_stb, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_cyc", a_cyc, 32'd0);
        chk("arst_stb", a_stb, 32'd0);
        chk("arst_grant", a_grant, 32'd0);
        chk("arst_err", a_m1_err, 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("arst_release_idle", a_grant, 32'd0);
        tick();
        settle();
        chk("arst_regrant", a_grant, 32'd2);
        chk("arst_regrant_cyc", a_cyc, 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
